// File: rtl/clock_core_1224_if.sv
// ---------------------------------------------------------------------------
// clock_core_1224_if
// Bundles the timekeeping core's control inputs and display outputs so that
// the core and its surroundings share a single connection point.
//
// Signals
//   tick       1  one-cycle pulse, one per second
//   mode       1  hour format: 0 = 24-hour, 1 = 12-hour
//   adj_m      1  one-cycle pulse: increment minutes
//   adj_h      1  one-cycle pulse: increment hours
//   sec_bcd    8  seconds as two BCD digits (tens in [7:4])
//   min_bcd    8  minutes as two BCD digits
//   hr_bcd     8  hour as two BCD digits, formatted per mode
//   pm         1  afternoon flag, only meaningful in 12-hour mode
//   hr24       5  raw binary hour 0..23
//   day_pulse  1  one-cycle pulse when the day rolls over
//
// Modports
//   master  drives the control inputs, observes the outputs
//   slave   the core itself
// ---------------------------------------------------------------------------
interface clock_core_1224_if;

    logic       tick;
    logic       mode;
    logic       adj_m;
    logic       adj_h;
    logic [7:0] sec_bcd;
    logic [7:0] min_bcd;
    logic [7:0] hr_bcd;
    logic       pm;
    logic [4:0] hr24;
    logic       day_pulse;

    modport master (
        output tick,
        output mode,
        output adj_m,
        output adj_h,
        input  sec_bcd,
        input  min_bcd,
        input  hr_bcd,
        input  pm,
        input  hr24,
        input  day_pulse
    );

    modport slave (
        input  tick,
        input  mode,
        input  adj_m,
        input  adj_h,
        output sec_bcd,
        output min_bcd,
        output hr_bcd,
        output pm,
        output hr24,
        output day_pulse
    );

endinterface

// File: rtl/clock_core_1224.sv
// ---------------------------------------------------------------------------
// clock_core_1224
// Timekeeping core of the digital clock. Keeps seconds, minutes and hours in
// 24-hour binary, applies minute/hour adjust pulses, and presents registered
// BCD digits for the seven-segment driver with the hour formatted in 12- or
// 24-hour style.
//
// Ports
//   clk   input   system clock, all state on the rising edge
//   rst   input   synchronous reset, active low
//   bus   slave   clock_core_1224_if: tick/mode/adj_m/adj_h in,
//                 sec_bcd/min_bcd/hr_bcd/pm/hr24/day_pulse out
//
// Build option
//   CLK_ADJ_SEC_CLEAR_EN  when defined, any adjust pulse also clears the
//                         seconds counter. Undefined by default, in which
//                         case adjusting leaves seconds untouched.
// ---------------------------------------------------------------------------
module clock_core_1224 (
    input  logic              clk,
    input  logic              rst,
    clock_core_1224_if.slave  bus
);

    // Binary time-of-day counters
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;

    logic [5:0] sec_nxt;
    logic [5:0] min_nxt;
    logic [4:0] hour_nxt;

    // Remembers that the last counter update was a full-day rollover, so the
    // pulse can line up with the formatted outputs showing 00:00:00.
    logic       roll_q;
    logic       roll_nxt;

    logic       adj_any;

    // Formatted values computed from the current counter state
    logic [4:0] disp_hour;
    logic       pm_nxt;

    // Binary 0..59 to two BCD digits. A compare chain keeps the tens digit
    // exact and avoids a general divider.
    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [3:0] tens;
        logic [3:0] units;
        if (v >= 6'd50) begin
            tens  = 4'd5;
            units = 4'(v - 6'd50);
        end else if (v >= 6'd40) begin
            tens  = 4'd4;
            units = 4'(v - 6'd40);
        end else if (v >= 6'd30) begin
            tens  = 4'd3;
            units = 4'(v - 6'd30);
        end else if (v >= 6'd20) begin
            tens  = 4'd2;
            units = 4'(v - 6'd20);
        end else if (v >= 6'd10) begin
            tens  = 4'd1;
            units = 4'(v - 6'd10);
        end else begin
            tens  = 4'd0;
            units = v[3:0];
        end
        return {tens, units};
    endfunction

    // Counter next-state. Adjust pulses take priority and swallow any tick in
    // the same cycle; the tick is dropped, not held over.
    always_comb begin
        sec_nxt  = sec;
        min_nxt  = min;
        hour_nxt = hour;
        roll_nxt = 1'b0;
        adj_any  = bus.adj_m | bus.adj_h;

        if (adj_any) begin
            if (bus.adj_m) begin
                min_nxt = (min == 6'd59) ? 6'd0 : min + 6'd1;
            end
            if (bus.adj_h) begin
                hour_nxt = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
            end
`ifdef CLK_ADJ_SEC_CLEAR_EN
            sec_nxt = 6'd0;
`else
            sec_nxt = sec;
`endif
        end else if (bus.tick) begin
            if (sec == 6'd59) begin
                sec_nxt = 6'd0;
                if (min == 6'd59) begin
                    min_nxt = 6'd0;
                    if (hour == 5'd23) begin
                        hour_nxt = 5'd0;
                        roll_nxt = 1'b1;
                    end else begin
                        hour_nxt = hour + 5'd1;
                    end
                end else begin
                    min_nxt = min + 6'd1;
                end
            end else begin
                sec_nxt = sec + 6'd1;
            end
        end
    end

    // Hour formatting. In 12-hour mode midnight and noon both read 12.
    always_comb begin
        disp_hour = hour;
        pm_nxt    = 1'b0;
        if (bus.mode) begin
            if (hour == 5'd0) begin
                disp_hour = 5'd12;
            end else if (hour > 5'd12) begin
                disp_hour = hour - 5'd12;
            end else begin
                disp_hour = hour;
            end
            pm_nxt = (hour >= 5'd12);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sec    <= 6'd0;
            min    <= 6'd0;
            hour   <= 5'd0;
            roll_q <= 1'b0;
        end else begin
            sec    <= sec_nxt;
            min    <= min_nxt;
            hour   <= hour_nxt;
            roll_q <= roll_nxt;
        end
    end

    // Output registers trail the counters by one edge and pick up the mode
    // present at that edge, so a mode change shows on the next cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.sec_bcd   <= 8'h00;
            bus.min_bcd   <= 8'h00;
            bus.hr_bcd    <= 8'h00;
            bus.pm        <= 1'b0;
            bus.hr24      <= 5'd0;
            bus.day_pulse <= 1'b0;
        end else begin
            bus.sec_bcd   <= to_bcd(sec);
            bus.min_bcd   <= to_bcd(min);
            bus.hr_bcd    <= to_bcd({1'b0, disp_hour});
            bus.pm        <= pm_nxt;
            bus.hr24      <= hour;
            bus.day_pulse <= roll_q;
        end
    end

endmodule

// File: tb/tb_clock_core_1224.sv
// ---------------------------------------------------------------------------
// tb_clock_core_1224
// Drives the timekeeping core with directed scenarios followed by random
// tick/adjust/mode/reset traffic. A reference model keeps the time of day as
// a plain second count and pushes the expected output word for every clock
// edge into a queue; an independent monitor pops and compares one entry
// after each rising edge.
// ---------------------------------------------------------------------------
module tb_clock_core_1224;

    logic clk;
    logic rst;

    clock_core_1224_if bus ();

    clock_core_1224 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected word: {sec_bcd, min_bcd, hr_bcd, pm, hr24, day_pulse}
    logic [30:0] exp_q[$];

    int checks_total;
    int checks_passed;
    int day_seen;
    int day_expected;

    // Reference state: seconds since midnight, plus whether the last update
    // was a midnight rollover.
    int model_t;
    bit model_rolled;

    function automatic logic [7:0] bcd_of(input int v);
        logic [7:0] r;
        r = 8'(((v / 10) << 4) | (v % 10));
        return r;
    endfunction

    function automatic logic [30:0] expected_word(input int t, input bit md, input bit day);
        int h;
        int m;
        int s;
        int shown;
        logic [7:0] hb;
        logic       p;
        h = t / 3600;
        m = (t / 60) % 60;
        s = t % 60;
        if (md) begin
            shown = (h % 12 == 0) ? 12 : h % 12;
            p     = (h >= 12);
        end else begin
            shown = h;
            p     = 1'b0;
        end
        hb = bcd_of(shown);
        return {bcd_of(s), bcd_of(m), hb, p, 5'(h), day};
    endfunction

    // Drive one clock edge worth of inputs, record what the outputs must show
    // after that edge, then advance the reference model.
    task automatic applyStimulus(input bit r_n, input bit tk, input bit am, input bit ah, input bit md);
        int h;
        int m;
        int s;
        @(negedge clk);
        rst       = r_n;
        bus.tick  = tk;
        bus.adj_m = am;
        bus.adj_h = ah;
        bus.mode  = md;
        if (!r_n) begin
            exp_q.push_back(31'd0);
            model_t      = 0;
            model_rolled = 1'b0;
        end else begin
            exp_q.push_back(expected_word(model_t, md, model_rolled));
            if (model_rolled) day_expected++;
            model_rolled = 1'b0;
            if (am || ah) begin
                h = model_t / 3600;
                m = (model_t / 60) % 60;
                s = model_t % 60;
                if (am) m = (m + 1) % 60;
                if (ah) h = (h + 1) % 24;
`ifdef CLK_ADJ_SEC_CLEAR_EN
                s = 0;
`endif
                model_t = h * 3600 + m * 60 + s;
            end else if (tk) begin
                model_t = (model_t + 1) % 86400;
                model_rolled = (model_t == 0);
            end
        end
    endtask

    task automatic checkOutput(input logic [30:0] exp_w);
        logic [30:0] act;
        act = {bus.sec_bcd, bus.min_bcd, bus.hr_bcd, bus.pm, bus.hr24, bus.day_pulse};
        checks_total++;
        if (act === exp_w) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL outputs at %0t: got sec=%h min=%h hr=%h pm=%b hr24=%0d day=%b, want sec=%h min=%h hr=%h pm=%b hr24=%0d day=%b",
                     $time, act[30:23], act[22:15], act[14:7], act[6], act[5:1], act[0],
                     exp_w[30:23], exp_w[22:15], exp_w[14:7], exp_w[6], exp_w[5:1], exp_w[0]);
        end
    endtask

    // Monitor: one expected entry per rising edge, sampled just after it.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            if (bus.day_pulse === 1'b1) day_seen++;
            checkOutput(exp_q.pop_front());
        end
    end

    task automatic idle(input int n, input bit md);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, md);
    endtask

    task automatic preset(input int h, input int m, input int s, input bit md);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, md);
        for (int i = 0; i < h; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, md);
        for (int i = 0; i < m; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, md);
        for (int i = 0; i < s; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, md);
    endtask

    initial begin
        int budget;
        bit md;
        checks_total  = 0;
        checks_passed = 0;
        day_seen      = 0;
        day_expected  = 0;
        model_t       = 0;
        model_rolled  = 1'b0;
        rst       = 1'b0;
        bus.tick  = 1'b0;
        bus.adj_m = 1'b0;
        bus.adj_h = 1'b0;
        bus.mode  = 1'b1;

        // Reset and release in both modes
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);

        // Midnight rollover from 23:59:58
        preset(23, 59, 58, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0);

        // Step through every hour in 12-hour mode, dropping to 24-hour at 15
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 24; i++) begin
            md = !(i >= 15 && i <= 16);
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, md);
        end
        idle(2, 1'b1);

        // Minute and hour wrap via adjust, no day pulse
        preset(23, 59, 0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b0);

        // Tick coincident with adjust at 10:20:30
        preset(10, 20, 30, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(2, 1'b1);

        // Reset coincident with tick at 12:34:56
        preset(12, 34, 56, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(2, 1'b1);

        // Random traffic
        md = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15) == 0) md = !md;
            applyStimulus(($urandom_range(199) != 0),
                          ($urandom_range(1) == 1),
                          ($urandom_range(7) == 0),
                          ($urandom_range(7) == 0),
                          md);
        end
        idle(2, md);

        // Let the monitor drain, bounded
        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #2;
        checks_total++;
        if (exp_q.size() == 0) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL drain: %0d entries left, want 0", exp_q.size());
        end

        checks_total++;
        if (day_seen == day_expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL day_pulse_count: got %0d, want %0d", day_seen, day_expected);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/clock_core_1224.md
# clock_core_1224

Timekeeping core of the digital clock: counts seconds, minutes and hours in 24-hour binary and formats the hour for display in 12- or 24-hour mode. It sits directly downstream of the 12/24 mode toggle, consuming its mode bit, and feeds BCD digits to the seven-segment display driver. Minute and hour adjust pulses from the button front end are applied here.

## Interface
Parameters:
- none (all widths fixed by time format)

Ports:
- clk  input  1  system clock; all state on rising edge
- rst  input  1  reset, synchronous, active-low
- tick  input  1  one-cycle pulse, one per second
- mode  input  1  hour format from mode toggle; 0 = 24-hour, 1 = 12-hour
- adj_m  input  1  one-cycle pulse: increment minutes
- adj_h  input  1  one-cycle pulse: increment hours
- sec_bcd  output  8  seconds, two BCD digits (tens in [7:4])
- min_bcd  output  8  minutes, two BCD digits
- hr_bcd  output  8  hour, two BCD digits, formatted per mode
- pm  output  1  1 when hour is 12..23 and mode = 1; 0 whenever mode = 0
- hr24  output  5  raw hour, binary 0..23
- day_pulse  output  1  one-cycle pulse on 23:59:59 -> 00:00:00 rollover by tick

## Operation
- State: sec 6-bit (0..59), min 6-bit (0..59), hour 5-bit (0..23), all binary.
- Tick (no adjust this cycle): sec+1; at 59 wraps to 0 and carries to min; min 59 wraps to 0 and carries to hour; hour 23 wraps to 0. Full rollover 23:59:59 -> 00:00:00 asserts day_pulse.
- adj_m: min+1, 59 wraps to 0, no carry into hour. Seconds unchanged (see Configuration).
- adj_h: hour+1, 23 wraps to 0, minutes and seconds unchanged.
- adj_m and adj_h same cycle: both applied independently.
- Any adjust pulse in a cycle suppresses tick for that cycle (tick dropped, not deferred); day_pulse never asserted by adjust.
- Display formatting (mode = 1): hour 0 -> 12 AM; 1..11 -> 1..11 AM; 12 -> 12 PM; 13..23 -> 1..11 PM. hr_bcd holds tens digit 0 or 1.
- Display formatting (mode = 0): hr_bcd = hour in BCD 00..23; pm = 0.
- Binary-to-BCD: tens = value/10, units = value%10, values never exceed 59.
- mode may change any cycle; counters unaffected, only formatting follows.

## Timing
- Counters update on the rising edge where tick/adj sampled high.
- All outputs registered: sec_bcd, min_bcd, hr_bcd, pm, hr24 reflect counter state and mode with exactly 1 cycle latency after the counter update (2 edges after stimulus sampled).
- day_pulse asserted in the same cycle the formatted outputs first show 00:00:00, high for one cycle.
- Reset (rst = 0 at edge): sec = min = hour = 0; all outputs 0 (sec_bcd 0x00, min_bcd 0x00, hr_bcd 0x00, pm 0, hr24 0, day_pulse 0). First edge after release: hr_bcd = 0x12 if mode = 1, else 0x00.
- Reset mid-count or coincident with tick/adj: reset wins, inputs ignored that cycle.
- Back-to-back tick on consecutive cycles legal; each advances by one.

## Configuration
- Macro CLK_ADJ_SEC_CLEAR_EN.
- Defined: adj_m (and adj_h) additionally clear seconds to 0 in the same edge; adjust still suppresses tick.
- Undefined: adjust leaves seconds untouched; default build.

## Test plan
- Reset with mode = 1, release -> one cycle later hr_bcd 0x12, pm 0, min_bcd 0x00, sec_bcd 0x00; with mode = 0 hr_bcd 0x00.
- Preload 23:59:58 via adjusts, two ticks -> 23:59:59 then 00:00:00 with day_pulse high exactly one cycle, hr24 0.
- mode = 1, step hour 0..23 via adj_h -> hr_bcd 12,01..11,12,01..11; pm 0 for 0..11, 1 for 12..23; toggle mode to 0 at hour 15 -> next cycle hr_bcd 0x15, pm 0.
- min = 59, adj_m -> min_bcd 0x00, hr24 unchanged; hour = 23, adj_h -> hr24 0, no day_pulse.
- tick and adj_m same cycle at 10:20:30 -> 10:21:30 (default) or 10:21:00 with CLK_ADJ_SEC_CLEAR_EN; tick not applied later.
- rst low coincident with tick at 12:34:56 -> all outputs 0 next cycle, counters 00:00:00.
